// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman tree-build controller.
// Node frame layout: weight [35:16], node_id [15:8], aux [7:0].
// A slot whose weight is all ones is empty.
package huff_pkg;

   localparam int unsigned NODE_W     = 36;
   localparam int unsigned WEIGHT_W   = 20;
   localparam int unsigned ID_W       = 8;

   localparam int unsigned WEIGHT_MSB = 35;
   localparam int unsigned WEIGHT_LSB = 16;
   localparam int unsigned ID_MSB     = 15;
   localparam int unsigned ID_LSB     = 8;
   localparam int unsigned AUX_MSB    = 7;
   localparam int unsigned AUX_LSB    = 0;

   localparam logic [NODE_W-1:0]   NODE_EMPTY   = 36'hF_FFFF_FFFF;
   localparam logic [WEIGHT_W-1:0] WEIGHT_EMPTY = 20'hFFFFF;
   localparam logic [WEIGHT_W-1:0] WEIGHT_SAT   = 20'hFFFFE;

   typedef enum logic [2:0] {
      StIdle,
      StFind1,
      StClr1,
      StFind2,
      StClr2,
      StEmit,
      StWrite,
      StDone
   } state_e;

   function automatic logic [WEIGHT_W-1:0] node_weight(input logic [NODE_W-1:0] node);
      return node[WEIGHT_MSB:WEIGHT_LSB];
   endfunction

endpackage

// File: rtl/huff_argmin.sv
// Combinational minimum finder over the node bank.
// Ports:
//   node_bus  - concatenated frames, slot 0 in the LSBs
//   min_frame - lowest-weight non-empty frame (NODE_EMPTY if none)
//   min_idx   - slot index of min_frame; ties resolve to the lowest index
//   any_valid - at least one slot is non-empty
module huff_argmin
   import huff_pkg::*;
#(
   parameter int unsigned NUM_UNITS = 8,
   parameter int unsigned IDX_W     = $clog2(NUM_UNITS)
) (
   input  logic [NODE_W*NUM_UNITS-1:0] node_bus,
   output logic [NODE_W-1:0]           min_frame,
   output logic [IDX_W-1:0]            min_idx,
   output logic                        any_valid
);

   // Empty slots carry the all-ones weight, which can never be strictly below the
   // running minimum, so they drop out without a separate valid mask. The strict
   // compare keeps the earlier (lower-index) slot on ties.
   always_comb begin
      min_frame = NODE_EMPTY;
      min_idx   = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (node_weight(node_bus[i*NODE_W +: NODE_W]) < node_weight(min_frame)) begin
            min_frame = node_bus[i*NODE_W +: NODE_W];
            min_idx   = IDX_W'(i);
         end
      end
   end

   assign any_valid = (node_weight(min_frame) != WEIGHT_EMPTY);

endmodule

// File: rtl/huff_min_merge.sv
// Huffman tree-build controller. Repeatedly finds and clears the two lightest
// nodes in the bank, hands the pair to the code-length stage, and writes the
// merged parent back into the slot of the lighter node until one node remains.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   start                 - pulse to begin a build (ignored unless idle)
//   node_bus              - node_out of all slots, slot 0 in the LSBs
//   clean, clean_en       - slot number to clear and its one-cycle strobe
//   node_in, node_wr      - parent frame and one-hot slot write enable
//   pair_out, pair_valid  - {min2, min1} frames offered downstream
//   pair_ready            - downstream accepts the pair
//   root_node             - last remaining frame, held until the next start
//   busy, done            - build in progress / one-cycle completion pulse
//   error                 - sticky: empty bank or weight saturation
module huff_min_merge
   import huff_pkg::*;
#(
   parameter int unsigned     NUM_UNITS      = 8,
   parameter logic [7:0]      UNIT_BASE      = 8'h00,
   parameter logic [ID_W-1:0] PARENT_ID_BASE = 8'h80
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NODE_W*NUM_UNITS-1:0] node_bus,
   output logic [7:0]                  clean,
   output logic                        clean_en,
   output logic [NODE_W-1:0]           node_in,
   output logic [NUM_UNITS-1:0]        node_wr,
   output logic [2*NODE_W-1:0]         pair_out,
   output logic                        pair_valid,
   input  logic                        pair_ready,
   output logic [NODE_W-1:0]           root_node,
   output logic                        busy,
   output logic                        done,
   output logic                        error
);

   localparam int unsigned IDX_W = $clog2(NUM_UNITS);

   state_e              state_q, state_d;
   logic [NODE_W-1:0]   min1_q, min1_d;
   logic [NODE_W-1:0]   min2_q, min2_d;
   logic [IDX_W-1:0]    idx1_q, idx1_d;
   logic [IDX_W-1:0]    idx2_q, idx2_d;
   logic [NODE_W-1:0]   root_q, root_d;
   logic                err_q, err_d;
   logic [ID_W-1:0]     pid_q, pid_d;

   logic [NODE_W-1:0]   scan_frame;
   logic [IDX_W-1:0]    scan_idx;
   logic                scan_valid;

   logic [WEIGHT_W:0]   sum_full;
   logic                sum_sat;
   logic [WEIGHT_W-1:0] sum_w;

   huff_argmin #(
      .NUM_UNITS (NUM_UNITS),
      .IDX_W     (IDX_W)
   ) u_argmin (
      .node_bus  (node_bus),
      .min_frame (scan_frame),
      .min_idx   (scan_idx),
      .any_valid (scan_valid)
   );

   // One extra bit so the sum of two 20-bit weights cannot wrap before the
   // saturation test; all-ones is reserved for "empty", so clamp one below it.
   assign sum_full = {1'b0, node_weight(min1_q)} + {1'b0, node_weight(min2_q)};
   assign sum_sat  = (sum_full >= {1'b0, WEIGHT_EMPTY});
   assign sum_w    = sum_sat ? WEIGHT_SAT : sum_full[WEIGHT_W-1:0];

   always_comb begin
      state_d    = state_q;
      min1_d     = min1_q;
      min2_d     = min2_q;
      idx1_d     = idx1_q;
      idx2_d     = idx2_q;
      root_d     = root_q;
      err_d      = err_q;
      pid_d      = pid_q;
      clean      = 8'h00;
      clean_en   = 1'b0;
      node_in    = '0;
      node_wr    = '0;
      pair_out   = '0;
      pair_valid = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               err_d   = 1'b0;
               root_d  = '0;
               state_d = StFind1;
            end
         end
         StFind1: begin
            if (!scan_valid) begin
               err_d   = 1'b1;
               root_d  = '0;
               state_d = StDone;
            end else begin
               min1_d  = scan_frame;
               idx1_d  = scan_idx;
               state_d = StClr1;
            end
         end
         StClr1: begin
            clean    = UNIT_BASE + 8'(idx1_q);
            clean_en = 1'b1;
            state_d  = StFind2;
         end
         StFind2: begin
            // min1's slot is already empty here, so an empty scan means min1 is the root.
            if (!scan_valid) begin
               root_d  = min1_q;
               state_d = StDone;
            end else begin
               min2_d  = scan_frame;
               idx2_d  = scan_idx;
               state_d = StClr2;
            end
         end
         StClr2: begin
            clean    = UNIT_BASE + 8'(idx2_q);
            clean_en = 1'b1;
            state_d  = StEmit;
         end
         StEmit: begin
            pair_valid = 1'b1;
            pair_out   = {min2_q, min1_q};
            if (pair_ready) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            node_wr = NUM_UNITS'(1'b1) << idx1_q;
            node_in = {sum_w, pid_q, 8'h00};
            if (sum_sat) begin
               err_d = 1'b1;
            end
            pid_d   = pid_q + 1'b1;
            state_d = StFind1;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy      = (state_q != StIdle) && (state_q != StDone);
   assign root_node = root_q;
   assign error     = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         min1_q  <= '0;
         min2_q  <= '0;
         idx1_q  <= '0;
         idx2_q  <= '0;
         root_q  <= '0;
         err_q   <= 1'b0;
         pid_q   <= PARENT_ID_BASE;
      end else begin
         state_q <= state_d;
         min1_q  <= min1_d;
         min2_q  <= min2_d;
         idx1_q  <= idx1_d;
         idx2_q  <= idx2_d;
         root_q  <= root_d;
         err_q   <= err_d;
         pid_q   <= pid_d;
      end
   end

endmodule

// File: tb/tb_huff_min_merge.sv
// Directed bench for huff_min_merge with a behavioural node bank model.
module tb_huff_min_merge;

   localparam int N = 8;
   localparam logic [35:0] EMPTY = 36'hF_FFFF_FFFF;

   logic             clk;
   logic             rst;
   logic             start;
   logic [36*N-1:0]  node_bus;
   logic [7:0]       clean;
   logic             clean_en;
   logic [35:0]      node_in;
   logic [N-1:0]     node_wr;
   logic [71:0]      pair_out;
   logic             pair_valid;
   logic             pair_ready;
   logic [35:0]      root_node;
   logic             busy;
   logic             done;
   logic             error;

   logic [35:0]      bank    [N];
   logic [35:0]      preload [N];
   logic             load;

   int               n_checks;
   int               n_fail;
   int               cyc;
   bit               pv;

   logic [71:0]      exp_pair [5];
   logic [7:0]       exp_wr   [5];
   logic [35:0]      exp_in   [5];

   logic [164:0]     outs;

   huff_min_merge #(
      .NUM_UNITS      (N),
      .UNIT_BASE      (8'h00),
      .PARENT_ID_BASE (8'h80)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .node_bus   (node_bus),
      .clean      (clean),
      .clean_en   (clean_en),
      .node_in    (node_in),
      .node_wr    (node_wr),
      .pair_out   (pair_out),
      .pair_valid (pair_valid),
      .pair_ready (pair_ready),
      .root_node  (root_node),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Node bank: write beats clear; load is a bench-only preload port.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < N; i++) bank[i] <= preload[i];
      end else if (node_wr != '0) begin
         for (int i = 0; i < N; i++) if (node_wr[i]) bank[i] <= node_in;
      end else if (clean_en) begin
         bank[clean[2:0]] <= EMPTY;
      end
   end

   always_comb begin
      node_bus = '0;
      for (int i = 0; i < N; i++) node_bus[i*36 +: 36] = bank[i];
   end

   assign outs = {busy, done, error, pair_valid, clean_en, clean, node_wr, node_in,
                  pair_out, root_node};

   function automatic logic [35:0] mk(input logic [19:0] w, input logic [7:0] id);
      return {w, id, 8'h00};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_preload();
      for (int i = 0; i < N; i++) preload[i] = EMPTY;
   endtask

   task automatic load_bank();
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits (negedge-sampled) for done or pair_valid; reports cycles waited and
   // whether pair_valid was seen along the way.
   task automatic wait_for(input bit want_done, input int limit, output int c, output bit seen);
      c    = 0;
      seen = 1'b0;
      while (c < limit && !(want_done ? done : pair_valid)) begin
         seen = seen | pair_valid;
         @(negedge clk);
         c++;
      end
      seen = seen | pair_valid;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      start      = 1'b0;
      pair_ready = 1'b1;
      load       = 1'b0;
      clear_preload();

      exp_pair[0] = {mk(20'd9, 8'h01),  mk(20'd5, 8'h00)};
      exp_wr[0]   = 8'h01;  exp_in[0] = mk(20'd14, 8'h80);
      exp_pair[1] = {mk(20'd13, 8'h03), mk(20'd12, 8'h02)};
      exp_wr[1]   = 8'h04;  exp_in[1] = mk(20'd25, 8'h81);
      exp_pair[2] = {mk(20'd16, 8'h04), mk(20'd14, 8'h80)};
      exp_wr[2]   = 8'h01;  exp_in[2] = mk(20'd30, 8'h82);
      exp_pair[3] = {mk(20'd30, 8'h82), mk(20'd25, 8'h81)};
      exp_wr[3]   = 8'h04;  exp_in[3] = mk(20'd55, 8'h83);
      exp_pair[4] = {mk(20'd55, 8'h83), mk(20'd45, 8'h05)};
      exp_wr[4]   = 8'h20;  exp_in[4] = mk(20'd100, 8'h84);

      // Reset state
      @(negedge clk);
      check("rst_outs_held", outs, '0);
      load_bank();
      rst = 1'b0;
      @(negedge clk);
      check("rst_outs_idle", outs, '0);

      // Test 1: full build of six weights
      preload[0] = mk(20'd5, 8'h00);
      preload[1] = mk(20'd9, 8'h01);
      preload[2] = mk(20'd12, 8'h02);
      preload[3] = mk(20'd13, 8'h03);
      preload[4] = mk(20'd16, 8'h04);
      preload[5] = mk(20'd45, 8'h05);
      load_bank();
      pulse_start();
      check("t1_busy", busy, 1);
      for (int m = 0; m < 5; m++) begin
         wait_for(1'b0, 20, cyc, pv);
         if (m == 1) start = 1'b0;
         check($sformatf("t1_latency%0d", m), cyc, (m == 0) ? 4 : 5);
         check($sformatf("t1_pair%0d", m), pair_out, exp_pair[m]);
         @(negedge clk);
         check($sformatf("t1_wr%0d", m), node_wr, exp_wr[m]);
         check($sformatf("t1_in%0d", m), node_in, exp_in[m]);
         check($sformatf("t1_noclr%0d", m), clean_en, 0);
         // start while busy must be ignored
         if (m == 0) start = 1'b1;
      end
      wait_for(1'b1, 20, cyc, pv);
      check("t1_done_latency", cyc, 4);
      check("t1_root", root_node, mk(20'd100, 8'h84));
      check("t1_error", error, 0);
      check("t1_busy_done", busy, 0);
      @(negedge clk);
      check("t1_done_pulse", done, 0);
      check("t1_root_hold", root_node, mk(20'd100, 8'h84));

      // Test 2: single node
      do_reset();
      clear_preload();
      preload[3] = mk(20'd7, 8'h03);
      load_bank();
      pulse_start();
      wait_for(1'b1, 20, cyc, pv);
      check("t2_timeout", cyc < 20, 1);
      check("t2_no_pair", pv, 0);
      check("t2_root", root_node, mk(20'd7, 8'h03));
      check("t2_error", error, 0);

      // Test 3: empty bank, then start during done is ignored
      do_reset();
      clear_preload();
      load_bank();
      pulse_start();
      wait_for(1'b1, 20, cyc, pv);
      check("t3_done_latency", cyc <= 2, 1);
      check("t3_error", error, 1);
      check("t3_root", root_node, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t3_start_in_done", busy, 0);
      check("t3_error_sticky", error, 1);

      // Test 4: equal weights, lowest index wins
      do_reset();
      clear_preload();
      preload[2] = mk(20'd4, 8'h02);
      preload[5] = mk(20'd4, 8'h05);
      preload[6] = mk(20'd4, 8'h06);
      load_bank();
      pulse_start();
      wait_for(1'b0, 20, cyc, pv);
      check("t4_pair", pair_out, {mk(20'd4, 8'h05), mk(20'd4, 8'h02)});
      @(negedge clk);
      check("t4_wr", node_wr, 8'h04);
      check("t4_in", node_in, mk(20'd8, 8'h80));
      @(negedge clk);
      check("t4_bank2", bank[2], mk(20'd8, 8'h80));
      wait_for(1'b1, 30, cyc, pv);
      check("t4_root", root_node, mk(20'd12, 8'h81));

      // Test 5: stall in EMIT
      do_reset();
      clear_preload();
      preload[0] = mk(20'd10, 8'h00);
      preload[1] = mk(20'd20, 8'h01);
      load_bank();
      pair_ready = 1'b0;
      pulse_start();
      wait_for(1'b0, 20, cyc, pv);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("t5_pair%0d", k), pair_out, {mk(20'd20, 8'h01), mk(20'd10, 8'h00)});
         check($sformatf("t5_valid%0d", k), pair_valid, 1);
         check($sformatf("t5_quiet%0d", k), {clean_en, node_wr}, 0);
         @(negedge clk);
      end
      pair_ready = 1'b1;
      @(negedge clk);
      check("t5_wr", node_wr, 8'h01);
      check("t5_in", node_in, mk(20'd30, 8'h80));
      wait_for(1'b1, 20, cyc, pv);
      check("t5_root", root_node, mk(20'd30, 8'h80));

      // Test 6: weight saturation
      do_reset();
      clear_preload();
      preload[0] = mk(20'hFFFF0, 8'h00);
      preload[1] = mk(20'h00020, 8'h01);
      load_bank();
      pulse_start();
      wait_for(1'b0, 20, cyc, pv);
      check("t6_pair", pair_out, {mk(20'hFFFF0, 8'h00), mk(20'h00020, 8'h01)});
      @(negedge clk);
      check("t6_wr", node_wr, 8'h02);
      check("t6_in", node_in, mk(20'hFFFFE, 8'h80));
      @(negedge clk);
      check("t6_error_set", error, 1);
      wait_for(1'b1, 20, cyc, pv);
      check("t6_root", root_node, mk(20'hFFFFE, 8'h80));
      check("t6_error_done", error, 1);

      // Test 7: reset mid-build
      do_reset();
      clear_preload();
      preload[0] = mk(20'd5, 8'h00);
      preload[1] = mk(20'd9, 8'h01);
      preload[2] = mk(20'd12, 8'h02);
      load_bank();
      pulse_start();
      wait_for(1'b0, 20, cyc, pv);
      check("t7_in_emit", pair_valid, 1);
      rst = 1'b1;
      #1;
      check("t7_outs_async", outs, '0);
      @(posedge clk);
      #1;
      check("t7_outs_edge", outs, '0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t7_idle_after", outs, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
